// File: rtl/round_sequencer.sv
// round_sequencer: iterative control for the block cipher round datapath.
// Ports: clk/rst; in_valid/in_ready/in_data host side; key_idx/key_in/key_valid
//   key store; rd_state/rd_key/rd_final/rd_result round datapath;
//   out_valid/out_ready/out_data result side; busy/round_cnt status.
module round_sequencer #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic [KW-1:0] key_idx,
  input  logic [127:0]  key_in,
  input  logic          key_valid,
  output logic [127:0]  rd_state,
  output logic [127:0]  rd_key,
  output logic          rd_final,
  input  logic [127:0]  rd_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic [KW-1:0] round_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WHITEN,
    ROUND,
    DONE
  } state_t;

  localparam logic [KW-1:0] LAST = KW'(NR);
  localparam logic [KW-1:0] ONE  = KW'(1);

  state_t        state;
  logic [127:0]  st_q;
  logic [KW-1:0] rnd;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          final_q;

  // Status flags are registered alongside the state so every output
  // is glitch-free; final_q is precomputed one step ahead of rnd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      st_q        <= '0;
      rnd         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st_q       <= in_data;
            rnd        <= '0;
            state      <= WHITEN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        WHITEN: begin
          if (key_valid) begin
            st_q    <= st_q ^ key_in;
            rnd     <= ONE;
            state   <= ROUND;
            final_q <= (LAST == ONE);
          end
        end
        ROUND: begin
          if (key_valid) begin
            st_q <= rd_result;
            if (final_q) begin
              state       <= DONE;
              final_q     <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              rnd     <= rnd + ONE;
              final_q <= ((rnd + ONE) == LAST);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rd_final  = final_q;
  assign key_idx   = rnd;
  assign round_cnt = rnd;
  assign rd_state  = st_q;
  assign rd_key    = key_in;
  assign out_data  = st_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: scoreboard bench for round_sequencer (NR=10 and NR=1)
// with key-store and round-datapath stubs.
module tb_round_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, key_valid, rd_final;
  logic         out_valid, out_ready, busy;
  logic [127:0] in_data, key_in, rd_state, rd_key, rd_result, out_data;
  logic [3:0]   key_idx, round_cnt;
  logic         kv_en;

  logic         in_valid1, in_ready1, key_valid1, rd_final1;
  logic         out_valid1, out_ready1, busy1;
  logic [127:0] in_data1, key_in1, rd_state1, rd_key1, rd_result1, out_data1;
  logic [3:0]   key_idx1, round_cnt1;

  assign key_in     = {16{4'h0, key_idx}};
  assign key_valid  = kv_en;
  assign rd_result  = (rd_state ^ rd_key) + {127'b0, rd_final};
  assign key_in1    = {16{4'h0, key_idx1}};
  assign key_valid1 = 1'b1;
  assign rd_result1 = (rd_state1 ^ rd_key1) + {127'b0, rd_final1};

  round_sequencer #(.NR(10), .KW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_in(key_in), .key_valid(key_valid),
    .rd_state(rd_state), .rd_key(rd_key), .rd_final(rd_final),
    .rd_result(rd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .round_cnt(round_cnt)
  );

  round_sequencer #(.NR(1), .KW(4)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .key_idx(key_idx1), .key_in(key_in1), .key_valid(key_valid1),
    .rd_state(rd_state1), .rd_key(rd_key1), .rd_final(rd_final1),
    .rd_result(rd_result1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .busy(busy1), .round_cnt(round_cnt1)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int exp_lat = 11;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] kval(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {16{4'h0, kk}};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] p,
                                         input int nr);
    logic [127:0] s;
    s = p ^ kval(0);
    for (int r = 1; r <= nr; r++)
      s = (s ^ kval(r)) + ((r == nr) ? 128'd1 : 128'd0);
    return s;
  endfunction

  typedef struct {
    logic [127:0] data;
    int           lat;
    int           acc;
  } sb_t;

  sb_t  q[$];
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready)
        q.push_back('{model(in_data, 10), exp_lat, cyc + 1});
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) check("sb_empty", 128'd1, 128'd0);
        else check("lat", 128'(cyc - q[0].acc), 128'(q[0].lat));
      end
      if (out_valid && out_ready && q.size() != 0) begin
        check("data", out_data, q[0].data);
        void'(q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rnd(input int r);
    int n;
    n = 0;
    while (!(busy && round_cnt == 4'(r)) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_rnd", 128'd0, 128'd1);
  endtask

  task automatic wait_out;
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_out", 128'd0, 128'd1);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_idle", 128'd0, 128'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, rf, rfr;
    logic [127:0] d;
    rst = 1'b1;
    in_valid = 0; in_data = '0; out_ready = 1'b1; kv_en = 1'b1;
    in_valid1 = 0; in_data1 = '0; out_ready1 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rd_final", 128'(rd_final), 128'd0);
    check("rst_key_idx", 128'(key_idx), 128'd0);
    check("rst_out_data", out_data, 128'd0);

    // single block: busy count and rd_final placement
    exp_lat = 11;
    in_data = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; rf = 0; rfr = 0;
    while (busy && n < 40) begin
      n++;
      if (rd_final) begin
        rf++;
        rfr = int'(round_cnt);
      end
      tick();
    end
    check("busy_cycles", 128'(n), 128'd12);
    check("rd_final_cnt", 128'(rf), 128'd1);
    check("rd_final_rnd", 128'(rfr), 128'd10);
    check("idle_ready", 128'(in_ready), 128'd1);

    // key stall: 1 cycle in WHITEN, 3 cycles at round 4
    exp_lat = 15;
    in_data = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    kv_en = 1'b0;
    tick();
    kv_en = 1'b1;
    wait_rnd(4);
    kv_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rnd", 128'(round_cnt), 128'd4);
    end
    kv_en = 1'b1;
    wait_out();
    tick();
    wait_idle();

    // output backpressure with in_valid held high
    exp_lat = 11;
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    in_data = d; in_valid = 1'b1;
    tick();
    wait_out();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data, model(d, 10));
      check("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", 128'(busy), 128'd1);
    wait_out();
    tick();
    wait_idle();

    // mid-op reset at round 6, then a fresh block
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_rnd(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", 128'(in_ready), 128'd1);
    check("mr_out_valid", 128'(out_valid), 128'd0);
    check("mr_busy", 128'(busy), 128'd0);
    check("mr_st_q", out_data, 128'd0);
    check("mr_key_idx", 128'(key_idx), 128'd0);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out();
    tick();
    wait_idle();

    // NR=1 build
    d = {$urandom, $urandom, $urandom, $urandom};
    in_data1 = d; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("n1_whiten_final", 128'(rd_final1), 128'd0);
    check("n1_whiten_ov", 128'(out_valid1), 128'd0);
    tick();
    check("n1_round_final", 128'(rd_final1), 128'd1);
    check("n1_round_ov", 128'(out_valid1), 128'd0);
    tick();
    check("n1_out_valid", 128'(out_valid1), 128'd1);
    check("n1_data", out_data1, model(d, 1));
    tick();
    check("n1_ready", 128'(in_ready1), 128'd1);

    tick();
    check("sb_left", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Iterative control for the block cipher round datapath. The block accepts one 128-bit plaintext block over a valid/ready handshake. It applies the initial key whitening, then drives the shared combinational round datapath once per round, fetching each round key from the key store. The finished block is presented over a valid/ready output handshake. It sits between the host interface and the round/key-store logic and owns the only state register of the cipher core.

## Interface
Parameters:
- NR, 10, number of full rounds after the initial whitening; legal 1..14
- KW, 4, width of key_idx; must satisfy 2**KW > NR

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data
- in_data  input  128  plaintext block
- key_idx  output  KW  round-key index requested from the key store
- key_in  input  128  round key for key_idx
- key_valid  input  1  key_in is valid for the current key_idx this cycle
- rd_state  output  128  state fed to the round datapath (= state register)
- rd_key  output  128  key fed to the round datapath (= key_in)
- rd_final  output  1  current round is the last one; the datapath skips diffusion
- rd_result  input  128  combinational round datapath result
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  ciphertext (= state register)
- busy  output  1  high in any state other than IDLE
- round_cnt  output  KW  current round counter, for debug/visibility

## Operation
- States: IDLE, WHITEN, ROUND, DONE. The state register is st_q[127:0]; the round counter is rnd[KW-1:0].
- IDLE:
  - in_ready=1.
  - On in_valid: st_q<=in_data, rnd<=0, go WHITEN.
- WHITEN:
  - key_idx=0.
  - On key_valid: st_q<=st_q^key_in, rnd<=1, go ROUND.
  - Without key_valid: hold all state.
- ROUND:
  - key_idx=rnd; rd_final=(rnd==NR).
  - On key_valid: st_q<=rd_result.
  - If rnd==NR, go DONE and leave rnd at NR. Otherwise rnd<=rnd+1.
  - Without key_valid: hold all state. The datapath result is discarded that cycle.
- DONE:
  - out_valid=1, out_data=st_q.
  - On out_ready: go IDLE. st_q is retained but no longer valid.
- Outputs outside their state:
  - rd_final=0 outside ROUND.
  - key_idx=rnd in all states; it is 0 in IDLE after reset.
  - in_ready=0 outside IDLE. out_valid=0 outside DONE.
- Stability: in_data is sampled only on the accept edge. Once out_valid rises, out_data must not change until the out handshake.
- rnd never exceeds NR and never wraps.
- round_cnt=rnd.
- No pipelining: exactly one block is in flight.

## Timing
- Reset: state=IDLE, st_q=0, rnd=0. Resulting outputs: in_ready=1, out_valid=0, busy=0, rd_final=0, key_idx=0, out_data=0.
- Reset has priority over every other input. Asserted mid-operation, it abandons the block, and in_ready is 1 the cycle after.
- Accept edge E0 is the edge where in_valid & in_ready. With key_valid held high:
  - WHITEN in cycle E0..E1.
  - Rounds 1..NR in the next NR cycles.
  - out_valid high from edge E0+NR+1.
  - For NR=10, out_valid rises 11 cycles after accept.
- Each key_valid-low cycle in WHITEN or ROUND adds exactly one cycle of latency.
- With out_ready already high, the out handshake completes in the first DONE cycle. in_ready returns the following cycle.
- Minimum block period is NR+3 cycles.
- in_valid while busy is ignored; in_ready=0 is the backpressure.
- Round key use:
  - Round key k is only consumed in a cycle where key_idx==k and key_valid=1.
  - The key store may change key_valid combinationally in response to key_idx.

## Test plan
Bench setup for all scenarios: NR=10. Key-store stub returns key_in={16{4'h0,key_idx}} with key_valid=1. Datapath stub gives rd_result=(rd_state^rd_key)+{127'b0,rd_final}.
- Reset then idle:
  - Stimulus: rst high 2 cycles, then released.
  - Required: in_ready=1, out_valid=0, busy=0, key_idx=0, out_data=0.
- Single block:
  - Stimulus: in_data=128'h0 accepted at E0, out_ready=1.
  - Required: out_valid rises at E0+11. out_data matches the model value for the stubs. busy is high for exactly 12 cycles. rd_final is high only in the round-10 cycle.
- Key stall:
  - Stimulus: key_valid dropped for 3 cycles at round 4 and 1 cycle in WHITEN.
  - Required: out_valid rises at E0+15 with the same out_data as the single-block case. round_cnt holds 4 during the stall.
- Output backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid held high throughout.
  - Required: out_data stable and in_ready=0 for those 5 cycles. After the out handshake, in_ready=1 the next cycle and the next block is accepted.
- Mid-op reset:
  - Stimulus: rst pulsed at round 6.
  - Required: next cycle state is IDLE, out_valid=0, st_q=0. A fresh block then completes with correct data.
- NR=1 build:
  - Stimulus: one block processed.
  - Required: out_valid at E0+2. rd_final is high in the only ROUND cycle.
